// File: rtl/if_fetch.sv
// Instruction fetch over a byte-wide memory port: four byte reads at pc..pc+3
// are assembled little-endian into one 32-bit instruction, held in DONE while stalled.
module if_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        ce_i,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_busy_i,
   input  logic [7:0]  mem_rdata_i,
   output logic        stallreq_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o
);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [2:0]  req_cnt_q, req_cnt_d;
   logic [2:0]  rcv_cnt_q, rcv_cnt_d;
   logic [23:0] buf_q, buf_d;
   logic        pend_q, pend_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_valid_q, if_valid_d;
   logic        abort;
   logic        accept;
   logic        unused_stall;

   assign unused_stall = ^stall[5:1];

   // Losing ce_i mid-fetch is treated exactly like a taken branch.
   assign abort      = branch_flag_i || (state_q == FETCH && !ce_i);
   assign mem_req_o  = (state_q == FETCH) && (req_cnt_q < 3'd4) && !abort;
   assign mem_addr_o = fetch_pc_q + {29'd0, req_cnt_q};
   assign accept     = mem_req_o && !mem_busy_i;
   assign stallreq_o = ce_i && (state_q != DONE) && !branch_flag_i;

   assign if_pc_o    = if_pc_q;
   assign if_inst_o  = if_inst_q;
   assign if_valid_o = if_valid_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_cnt_d  = req_cnt_q;
      rcv_cnt_d  = rcv_cnt_q;
      buf_d      = buf_q;
      pend_d     = 1'b0;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_valid_d = if_valid_q;

      if (abort) begin
         state_d    = IDLE;
         req_cnt_d  = 3'd0;
         rcv_cnt_d  = 3'd0;
         if_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ce_i) begin
                  fetch_pc_d = pc_i;
                  req_cnt_d  = 3'd0;
                  rcv_cnt_d  = 3'd0;
                  state_d    = FETCH;
               end
            end
            FETCH: begin
               if (accept) begin
                  req_cnt_d = req_cnt_q + 3'd1;
                  pend_d    = 1'b1;
               end
               // pend_q marks that mem_rdata_i carries the byte accepted last cycle.
               if (pend_q) begin
                  rcv_cnt_d = rcv_cnt_q + 3'd1;
                  unique case (rcv_cnt_q)
                     3'd0: buf_d[7:0]   = mem_rdata_i;
                     3'd1: buf_d[15:8]  = mem_rdata_i;
                     3'd2: buf_d[23:16] = mem_rdata_i;
                     default: begin
                        if_inst_d  = {mem_rdata_i, buf_q};
                        if_pc_d    = fetch_pc_q;
                        if_valid_d = 1'b1;
                        state_d    = DONE;
                     end
                  endcase
               end
            end
            DONE: begin
               if (!stall[0]) begin
                  state_d    = IDLE;
                  if_valid_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= 32'd0;
         req_cnt_q  <= 3'd0;
         rcv_cnt_q  <= 3'd0;
         buf_q      <= 24'd0;
         pend_q     <= 1'b0;
         if_pc_q    <= 32'd0;
         if_inst_q  <= 32'd0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_cnt_q  <= req_cnt_d;
         rcv_cnt_q  <= rcv_cnt_d;
         buf_q      <= buf_d;
         pend_q     <= pend_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_valid_q <= if_valid_d;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a table of complete fetches plus hand-written
// branch, DONE-stall and reset sequences against a one-cycle-latency byte memory.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        ce_i;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_busy_i;
   logic [7:0]  mem_rdata_i;
   logic        stallreq_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  b0, b1, b2, b3;
      int          busy_idx;
      int          busy_n;
      logic [31:0] inst;
      int          lat;
   } vec_t;

   vec_t        vecs[6];
   int          nvec = 0;
   int          nfail = 0;
   logic [31:0] mem_base;
   logic [7:0]  m0, m1, m2, m3;

   if_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .ce_i         (ce_i),
      .stall        (stall),
      .branch_flag_i(branch_flag_i),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_busy_i   (mem_busy_i),
      .mem_rdata_i  (mem_rdata_i),
      .stallreq_o   (stallreq_o),
      .if_pc_o      (if_pc_o),
      .if_inst_o    (if_inst_o),
      .if_valid_o   (if_valid_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      logic [31:0] off;
      off = a - mem_base;
      case (off)
         32'd0:   return m0;
         32'd1:   return m1;
         32'd2:   return m2;
         32'd3:   return m3;
         default: return 8'hEE;
      endcase
   endfunction

   // Accepted reads return one cycle later; anything else returns junk.
   always @(posedge clk) begin
      if (mem_req_o && !mem_busy_i) mem_rdata_i <= byte_at(mem_addr_o);
      else                          mem_rdata_i <= 8'hEE;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Entered just after the negedge of an IDLE cycle; returns in the IDLE cycle after DONE.
   task automatic run_fetch(input vec_t v, input int hold);
      int req_idx, busy_left, k;
      bit got;
      mem_base = v.pc;
      m0 = v.b0; m1 = v.b1; m2 = v.b2; m3 = v.b3;
      pc_i  = v.pc;
      ce_i  = 1'b1;
      stall = (hold > 0) ? 6'b000001 : 6'b000000;
      #1;
      chk("idle_req", 32'(mem_req_o), 32'd0);
      chk("idle_stallreq", 32'(stallreq_o), 32'd1);
      req_idx = 0; busy_left = v.busy_n; k = 0; got = 0;
      while (!got && k < 40) begin
         step(); k++;
         mem_busy_i = (busy_left > 0 && req_idx == v.busy_idx && mem_req_o);
         if (mem_busy_i) busy_left--;
         #1;
         if (if_valid_o) got = 1;
         else if (mem_req_o) begin
            chk("addr", mem_addr_o, v.pc + 32'(req_idx));
            if (!mem_busy_i) req_idx++;
         end
      end
      mem_busy_i = 1'b0;
      if (!got) begin
         nvec++; nfail++;
         $display("FAIL timeout: got no if_valid_o after %0d cycles, want one", k);
      end else begin
         chk("latency", 32'(k), 32'(v.lat));
         chk("inst", if_inst_o, v.inst);
         chk("pc", if_pc_o, v.pc);
         chk("done_stallreq", 32'(stallreq_o), 32'd0);
         chk("done_req", 32'(mem_req_o), 32'd0);
         chk("req_count", 32'(req_idx), 32'd4);
      end
      for (int h = 1; h <= hold; h++) begin
         step();
         if (h == hold) stall = 6'b000000;
         #1;
         chk("hold_valid", 32'(if_valid_o), 32'd1);
         chk("hold_inst", if_inst_o, v.inst);
      end
      step();
      ce_i = 1'b0;
      #1;
      chk("valid_clear", 32'(if_valid_o), 32'd0);
   endtask

   initial begin
      vecs[0] = '{32'h00000100, 8'h13, 8'h05, 8'hA0, 8'h00, -1, 0, 32'h00A00513, 6};
      vecs[1] = '{32'h00000100, 8'h13, 8'h05, 8'hA0, 8'h00,  1, 2, 32'h00A00513, 8};
      vecs[2] = '{32'hFFFFFFFE, 8'h93, 8'h00, 8'h10, 8'h00, -1, 0, 32'h00100093, 6};
      vecs[3] = '{32'h00002000, 8'h78, 8'h56, 8'h34, 8'h12,  0, 1, 32'h12345678, 7};
      vecs[4] = '{32'h80000000, 8'hFF, 8'hFF, 8'hFF, 8'hFF,  3, 3, 32'hFFFFFFFF, 9};
      vecs[5] = '{32'h00000400, 8'h37, 8'h04, 8'h00, 8'h00, -1, 0, 32'h00000437, 6};

      rst = 1'b1; pc_i = 32'd0; ce_i = 1'b0; stall = 6'd0;
      branch_flag_i = 1'b0; mem_busy_i = 1'b0; mem_base = 32'd0;
      m0 = 8'd0; m1 = 8'd0; m2 = 8'd0; m3 = 8'd0;
      repeat (3) step();
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(if_valid_o), 32'd0);
      chk("rst_inst", if_inst_o, 32'd0);
      chk("rst_pc", if_pc_o, 32'd0);
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_stallreq", 32'(stallreq_o), 32'd0);

      for (int i = 0; i < 5; i++) run_fetch(vecs[i], 0);

      // Branch after two bytes received; the in-flight third byte must be dropped.
      mem_base = 32'h300; m0 = 8'h11; m1 = 8'h22; m2 = 8'h33; m3 = 8'h44;
      pc_i = 32'h300; ce_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step(); #1;
         chk("br_addr", mem_addr_o, 32'h300 + 32'(k - 1));
      end
      step(); branch_flag_i = 1'b1; #1;
      chk("br_stallreq", 32'(stallreq_o), 32'd0);
      chk("br_req", 32'(mem_req_o), 32'd0);
      step(); branch_flag_i = 1'b0; #1;
      chk("br_idle_valid", 32'(if_valid_o), 32'd0);
      run_fetch(vecs[5], 0);

      run_fetch(vecs[0], 3);

      // Reset in the middle of a fetch clears the previously presented instruction.
      mem_base = 32'h500; pc_i = 32'h500; ce_i = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0; ce_i = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(if_valid_o), 32'd0);
      chk("mid_rst_inst", if_inst_o, 32'd0);
      chk("mid_rst_pc", if_pc_o, 32'd0);
      chk("mid_rst_req", 32'(mem_req_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step(); #1;
         chk("ce0_req", 32'(mem_req_o), 32'd0);
         chk("ce0_stallreq", 32'(stallreq_o), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
